lsu_mem_ctrl: RTL

//  Data-memory access controller downstream of the LSU address/extension logic.
//  - Accepts one load/store per request from EXE and drives a req/gnt + rvalid data bus.
//  - Generates byte enables and replicated store data.
//  - Stalls the pipeline until the response returns.
//  - Returns the raw memory word, which the LSU aligns and extends.
//  - Detects misalignment, bus errors and bus timeouts.

---
 rtl/lsu_mem_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/lsu_mem_ctrl.sv
// Data-memory access controller: turns one LSU load/store into a req/gnt + rvalid bus
// transaction, generating byte enables and replicated store data, with misalign/fault/timeout detection.
module lsu_mem_ctrl #(
   parameter int XLEN     = 32,
   parameter int MAX_WAIT = 255
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid_i,
   input  logic            req_store_i,
   input  logic [XLEN-1:0] req_adr_i,
   input  logic [2:0]      req_size_i,
   input  logic [XLEN-1:0] req_wdata_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] load_data_o,
   output logic            misalign_o,
   output logic            access_fault_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [XLEN-1:0] mem_adr_o,
   output logic [3:0]      mem_be_o,
   output logic [XLEN-1:0] mem_wdata_o,
   input  logic            mem_gnt_i,
   input  logic            mem_rvalid_i,
   input  logic [XLEN-1:0] mem_rdata_i,
   input  logic            mem_err_i
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RSP  = 2'd2
   } state_t;

   state_t           state_r;
   logic [CNT_W-1:0] wait_cnt_r;
   logic             flushed_r;
   logic             misalign_s;
   logic             accept_s;
   logic             timeout_s;

   // Anything that is not a clean byte/half one-hot code is handled as a word access.
   function automatic logic [3:0] calc_be(input logic [2:0] size, input logic [1:0] lo);
      case (size)
         3'b001:  calc_be = 4'b0001 << lo;
         3'b010:  calc_be = 4'b0011 << lo;
         default: calc_be = 4'b1111;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] calc_wdata(input logic [2:0] size, input logic [XLEN-1:0] d);
      case (size)
         3'b001:  calc_wdata = {(XLEN/8){d[7:0]}};
         3'b010:  calc_wdata = {(XLEN/16){d[15:0]}};
         default: calc_wdata = d;
      endcase
   endfunction

   // Request decode: alignment check, acceptance and wait-budget expiry.
   always_comb begin
      misalign_s = 1'b0;
      case (req_size_i)
         3'b001:  misalign_s = 1'b0;
         3'b010:  misalign_s = req_adr_i[0];
         default: misalign_s = (req_adr_i[1:0] != 2'b00);
      endcase
      accept_s  = (state_r == IDLE) && req_valid_i && !flush_i && !misalign_s;
      timeout_s = (state_r != IDLE) && (wait_cnt_r == CNT_W'(MAX_WAIT - 1));
   end

   assign stall_o = (state_r != IDLE) || accept_s;

   // Transaction FSM with registered bus and result outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r        <= IDLE;
         wait_cnt_r     <= {CNT_W{1'b0}};
         flushed_r      <= 1'b0;
         done_o         <= 1'b0;
         misalign_o     <= 1'b0;
         access_fault_o <= 1'b0;
         load_data_o    <= {XLEN{1'b0}};
         mem_req_o      <= 1'b0;
         mem_we_o       <= 1'b0;
         mem_adr_o      <= {XLEN{1'b0}};
         mem_be_o       <= 4'b0000;
         mem_wdata_o    <= {XLEN{1'b0}};
      end else begin
         done_o         <= 1'b0;
         misalign_o     <= 1'b0;
         access_fault_o <= 1'b0;
         case (state_r)
            IDLE: begin
               if (req_valid_i && !flush_i && misalign_s) begin
                  misalign_o <= 1'b1;
               end else if (accept_s) begin
                  state_r     <= REQ;
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= req_store_i;
                  mem_adr_o   <= {req_adr_i[XLEN-1:2], 2'b00};
                  mem_be_o    <= calc_be(req_size_i, req_adr_i[1:0]);
                  mem_wdata_o <= req_store_i ? calc_wdata(req_size_i, req_wdata_i) : {XLEN{1'b0}};
                  wait_cnt_r  <= {CNT_W{1'b0}};
                  flushed_r   <= 1'b0;
               end
            end
            REQ: begin
               wait_cnt_r <= wait_cnt_r + CNT_W'(1);
               // A grant in the last budget cycle cannot be answered in time, so the budget wins.
               if (timeout_s) begin
                  state_r        <= IDLE;
                  mem_req_o      <= 1'b0;
                  access_fault_o <= 1'b1;
               end else if (mem_gnt_i) begin
                  state_r   <= RSP;
                  mem_req_o <= 1'b0;
                  flushed_r <= flush_i;
               end else if (flush_i) begin
                  state_r   <= IDLE;
                  mem_req_o <= 1'b0;
               end
            end
            RSP: begin
               wait_cnt_r <= wait_cnt_r + CNT_W'(1);
               if (mem_rvalid_i) begin
                  state_r   <= IDLE;
                  flushed_r <= 1'b0;
                  if (!flushed_r && !flush_i) begin
                     if (mem_err_i) begin
                        access_fault_o <= 1'b1;
                     end else begin
                        done_o <= 1'b1;
                        if (!mem_we_o) begin
                           load_data_o <= mem_rdata_i;
                        end
                     end
                  end
               end else if (timeout_s) begin
                  state_r        <= IDLE;
                  flushed_r      <= 1'b0;
                  access_fault_o <= !(flushed_r || flush_i);
               end else if (flush_i) begin
                  flushed_r <= 1'b1;
               end
            end
            default: begin
               state_r   <= IDLE;
               mem_req_o <= 1'b0;
               flushed_r <= 1'b0;
            end
         endcase
      end
   end

endmodule
